iter_shift_unit: RTL and testbench

//  Multi-cycle parametrised shifter for the ALU shift path. It generalises the single-bit
//  SLL/SRL/SRA stage to any shift amount and any data width. It iterates STEP bit positions
//  per clock under a valid/ready handshake, and sits beside the combinational ALU on the

---
 rtl/iter_shift_unit.sv | 145 ++++++++++++++
 tb/tb_iter_shift_unit.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_shift_unit.sv
// iter_shift_unit: multi-cycle SLL/SRL/SRA (optional ROR) shifter that moves
// STEP bit positions per clock behind a valid/ready handshake.
// Ports: clk, rst_n (sync, active low); in_valid/in_ready, in_data, in_shamt,
//        in_fun (00 SLL, 01 SRL, 11 SRA, 10 ROR/SRL), in_en (0: pass through);
//        out_valid/out_ready, out_data; busy (high while SHIFT or DONE).
// Build option: define ITER_SHIFT_ROTATE_EN to make in_fun=10 a rotate right;
//               otherwise in_fun=10 behaves as SRL and no rotate logic exists.
module iter_shift_unit #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH),
   parameter int STEP    = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_fun,
   input  logic               in_en,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               busy
);

   // Wide enough to hold WIDTH itself (the saturated shift amount).
   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [CNT_W-1:0] STEP_C  = CNT_W'(STEP);
   localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   work;
   logic [1:0]         fun;
   logic               sign;
   logic [CNT_W-1:0]   remaining;

   logic [31:0]        shamt_ext;
   logic [CNT_W-1:0]   cap_amt;
   logic [CNT_W-1:0]   k;
   logic [WIDTH-1:0]   srl_res;
   logic [WIDTH-1:0]   fill;
   logic [WIDTH-1:0]   step_res;

   // Amounts at or beyond WIDTH saturate to WIDTH: after WIDTH positions a
   // logical shift is all zeros and an arithmetic one is all sign bits.
   always_comb begin
      shamt_ext = 32'(in_shamt);
      if (shamt_ext >= 32'(WIDTH))
         cap_amt = WIDTH_C;
      else
         cap_amt = CNT_W'(shamt_ext);
   end

   // Final step may be shorter than STEP.
   always_comb begin
      if (remaining >= STEP_C)
         k = STEP_C;
      else
         k = remaining;
   end

   // Sign captured at request time fills the vacated MSBs for SRA.
   always_comb begin
      srl_res = work >> k;
      fill    = '0;
      if (sign)
         fill = ~({WIDTH{1'b1}} >> k);
      step_res = srl_res;
      unique case (fun)
         2'b00: step_res = work << k;
         2'b11: step_res = srl_res | fill;
`ifdef ITER_SHIFT_ROTATE_EN
         2'b10: step_res = srl_res | (work << (WIDTH_C - k));
`else
         2'b10: step_res = srl_res;
`endif
         2'b01: step_res = srl_res;
      endcase
   end

   // DONE is entered one cycle before out_valid rises; that cycle latches
   // the finished word into out_data, so out_data only changes on a result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         out_data  <= '0;
         work      <= '0;
         fun       <= 2'b00;
         sign      <= 1'b0;
         remaining <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  work      <= in_data;
                  fun       <= in_fun;
                  sign      <= in_data[WIDTH-1];
                  remaining <= cap_amt;
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
                  if (!in_en || cap_amt == '0)
                     state <= DONE;
                  else
                     state <= SHIFT;
               end
            end
            SHIFT: begin
               work      <= step_res;
               remaining <= remaining - k;
               if (remaining == k)
                  state <= DONE;
            end
            DONE: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  out_data  <= work;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iter_shift_unit.sv
// tb_iter_shift_unit: checks iter_shift_unit with STEP=1 and STEP=4 instances
// side by side against an arithmetic reference model.
module tb_iter_shift_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_data;
   logic [4:0]  in_shamt;
   logic [1:0]  in_fun;
   logic        in_en;
   logic        out_ready;

   logic        ir1, ov1, b1;
   logic [31:0] od1;
   logic        ir4, ov4, b4;
   logic [31:0] od4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   iter_shift_unit #(.WIDTH(32), .STEP(1)) u1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(ir1),
      .in_data(in_data), .in_shamt(in_shamt),
      .in_fun(in_fun), .in_en(in_en),
      .out_valid(ov1), .out_ready(out_ready),
      .out_data(od1), .busy(b1)
   );

   iter_shift_unit #(.WIDTH(32), .STEP(4)) u4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(ir4),
      .in_data(in_data), .in_shamt(in_shamt),
      .in_fun(in_fun), .in_en(in_en),
      .out_valid(ov4), .out_ready(out_ready),
      .out_data(od4), .busy(b4)
   );

   function automatic logic [31:0] model(input logic [31:0] d,
                                         input logic [4:0] s,
                                         input logic [1:0] f,
                                         input logic en);
      logic [5:0] inv;
      if (!en) return d;
      inv = 6'd32 - {1'b0, s};
      case (f)
         2'b00: return d << s;
         2'b01: return d >> s;
         2'b11: return 32'($signed(d) >>> s);
`ifdef ITER_SHIFT_ROTATE_EN
         default: return (d >> s) | (d << inv);
`else
         default: return d >> s;
`endif
      endcase
   endfunction

   function automatic int lat(input logic [4:0] s, input logic en,
                              input int step);
      if (!en || s == 0) return 1;
      return 1 + (int'(s) + step - 1) / step;
   endfunction

   // Issues one request (out_ready=1) and records result and edge count
   // from acceptance until out_valid for each instance; -1 on timeout.
   task automatic run_op(input logic [31:0] d, input logic [4:0] s,
                         input logic [1:0] f, input logic en,
                         output logic [31:0] r1, output int l1,
                         output logic [31:0] r4, output int l4);
      bit g1, g4;
      g1 = 0; g4 = 0;
      r1 = '0; r4 = '0; l1 = -1; l4 = -1;
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = d;
      in_shamt  = s;
      in_fun    = f;
      in_en     = en;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = $urandom;
      in_shamt = 5'($urandom);
      for (int c = 1; c <= 200 && !(g1 && g4); c++) begin
         @(posedge clk);
         #1;
         if (!g1 && ov1) begin g1 = 1; r1 = od1; l1 = c; end
         if (!g4 && ov4) begin g4 = 1; r4 = od4; l4 = c; end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; in_shamt = '0; in_fun = '0; in_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({ir1, ov1, b1, od1} !== {3'b100, 32'h0}) begin
         bad++;
         $display("FAIL reset_u1 got ir=%b ov=%b busy=%b d=%h want 1 0 0 0",
                  ir1, ov1, b1, od1);
      end
      total++;
      if ({ir4, ov4, b4, od4} !== {3'b100, 32'h0}) begin
         bad++;
         $display("FAIL reset_u4 got ir=%b ov=%b busy=%b d=%h want 1 0 0 0",
                  ir4, ov4, b4, od4);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed;
      logic [31:0] r1, r4, e;
      int l1, l4;
      // SRA 0x80000000 by 4
      run_op(32'h8000_0000, 5'd4, 2'b11, 1'b1, r1, l1, r4, l4);
      total++;
      if (r1 !== 32'hF800_0000 || l1 !== 5) begin
         bad++;
         $display("FAIL sra4_u1 got %h lat %0d want f8000000 lat 5", r1, l1);
      end
      total++;
      if (r4 !== 32'hF800_0000 || l4 !== 2) begin
         bad++;
         $display("FAIL sra4_u4 got %h lat %0d want f8000000 lat 2", r4, l4);
      end
      // SRL of the same operand
      run_op(32'h8000_0000, 5'd4, 2'b01, 1'b1, r1, l1, r4, l4);
      total++;
      if (r1 !== 32'h0800_0000 || r4 !== 32'h0800_0000) begin
         bad++;
         $display("FAIL srl4 got %h/%h want 08000000", r1, r4);
      end
      // SLL 1 by 31
      run_op(32'h1, 5'd31, 2'b00, 1'b1, r1, l1, r4, l4);
      total++;
      if (r4 !== 32'h8000_0000 || l4 !== 9) begin
         bad++;
         $display("FAIL sll31_u4 got %h lat %0d want 80000000 lat 9", r4, l4);
      end
      total++;
      if (r1 !== 32'h8000_0000 || l1 !== 32) begin
         bad++;
         $display("FAIL sll31_u1 got %h lat %0d want 80000000 lat 32", r1, l1);
      end
      // pass through
      run_op(32'h1, 5'd31, 2'b00, 1'b0, r1, l1, r4, l4);
      total++;
      if (r1 !== 32'h1 || r4 !== 32'h1 || l1 !== 1 || l4 !== 1) begin
         bad++;
         $display("FAIL en0 got %h/%h lat %0d/%0d want 1 lat 1",
                  r1, r4, l1, l4);
      end
      // zero shift amount
      run_op(32'hA5A5_0F0F, 5'd0, 2'b11, 1'b1, r1, l1, r4, l4);
      total++;
      if (r1 !== 32'hA5A5_0F0F || r4 !== 32'hA5A5_0F0F || l1 !== 1 || l4 !== 1) begin
         bad++;
         $display("FAIL shamt0 got %h/%h lat %0d/%0d want a5a50f0f lat 1",
                  r1, r4, l1, l4);
      end
      // ROR / SRL fallback
      run_op(32'h3, 5'd1, 2'b10, 1'b1, r1, l1, r4, l4);
`ifdef ITER_SHIFT_ROTATE_EN
      e = 32'h8000_0001;
`else
      e = 32'h0000_0001;
`endif
      total++;
      if (r1 !== e || r4 !== e || l1 !== 2 || l4 !== 2) begin
         bad++;
         $display("FAIL ror1 got %h/%h lat %0d/%0d want %h lat 2",
                  r1, r4, l1, l4, e);
      end
   endtask

   task automatic test_random;
      logic [31:0] r1, r4, d, e;
      logic [4:0]  s;
      logic [1:0]  f;
      logic        en;
      int l1, l4;
      for (int i = 0; i < 40; i++) begin
         d  = $urandom;
         s  = 5'($urandom_range(0, 31));
         f  = 2'($urandom_range(0, 3));
         en = ($urandom_range(0, 7) != 0);
         e  = model(d, s, f, en);
         run_op(d, s, f, en, r1, l1, r4, l4);
         total++;
         if (r1 !== e || l1 !== lat(s, en, 1)) begin
            bad++;
            $display("FAIL rand_u1 d=%h s=%0d f=%b en=%b got %h lat %0d want %h lat %0d",
                     d, s, f, en, r1, l1, e, lat(s, en, 1));
         end
         total++;
         if (r4 !== e || l4 !== lat(s, en, 4)) begin
            bad++;
            $display("FAIL rand_u4 d=%h s=%0d f=%b en=%b got %h lat %0d want %h lat %0d",
                     d, s, f, en, r4, l4, e, lat(s, en, 4));
         end
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] d, e;
      int n;
      d = $urandom | 32'h8000_0000;
      e = model(d, 5'd7, 2'b11, 1'b1);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = d;
      in_shamt  = 5'd7;
      in_fun    = 2'b11;
      in_en     = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 0;
      while (!(ov1 && ov4) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      total++;
      if (n >= 100) begin
         bad++;
         $display("FAIL bp_timeout got ov=%b/%b want 1/1", ov1, ov4);
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         total++;
         if ({ov1, ir1, b1, od1} !== {3'b101, e} ||
             {ov4, ir4, b4, od4} !== {3'b101, e}) begin
            bad++;
            $display("FAIL bp_hold got %b%b%b %h / %b%b%b %h want 101 %h",
                     ov1, ir1, b1, od1, ov4, ir4, b4, od4, e);
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if ({ov1, ir1, b1} !== 3'b010 || {ov4, ir4, b4} !== 3'b010) begin
         bad++;
         $display("FAIL bp_release got %b%b%b/%b%b%b want 010/010",
                  ov1, ir1, b1, ov4, ir4, b4);
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] r1, r4, e;
      int l1, l4;
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h0000_0ABC;
      in_shamt  = 5'd20;
      in_fun    = 2'b00;
      in_en     = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if ({ir1, ov1, b1, ir4, ov4, b4} !== 6'b100100) begin
         bad++;
         $display("FAIL midrst_idle got %b%b%b/%b%b%b want 100/100",
                  ir1, ov1, b1, ir4, ov4, b4);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         total++;
         if (ov1 !== 1'b0 || ov4 !== 1'b0) begin
            bad++;
            $display("FAIL midrst_quiet got ov=%b/%b want 0/0", ov1, ov4);
         end
      end
      e = model(32'hDEAD_BEEF, 5'd13, 2'b11, 1'b1);
      run_op(32'hDEAD_BEEF, 5'd13, 2'b11, 1'b1, r1, l1, r4, l4);
      total++;
      if (r1 !== e || r4 !== e || l1 !== 14 || l4 !== 5) begin
         bad++;
         $display("FAIL midrst_after got %h/%h lat %0d/%0d want %h lat 14/5",
                  r1, r4, l1, l4, e);
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_backpressure;
      test_reset_mid;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
